// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM output datapath: drain FSM states,
// the default word width and the beat-counter width helper.
package gemm_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    localparam int GEMM_WORD_WIDTH = 32;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gemm_drain_reg.sv
// Team register: clock-enabled storage with synchronous active-high reset.
module gemm_drain_reg #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic [WORD_WIDTH-1:0] d_i,
    output logic [WORD_WIDTH-1:0] q_o
);

    logic [WORD_WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (clk_en) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/gemm_drain.sv
// GEMM output stage: parallel row load, serialised onto a valid/ready word stream.
// Optional stall counter enabled by GEMM_DRAIN_STALL_CNT_EN.
module gemm_drain
    import gemm_pkg::*;
#(
    parameter int WORD_WIDTH = GEMM_WORD_WIDTH,
    parameter int NUM_WORDS  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_load,
    input  logic [WORD_WIDTH*NUM_WORDS-1:0] i_data,
    output logic                            i_ready,
    output logic                            o_tvalid,
    output logic [WORD_WIDTH-1:0]           o_tdata,
    output logic                            o_tlast,
    input  logic                            i_tready,
    output logic [31:0]                     o_stall_cycles
);

    localparam int CNT_W = cnt_width(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    drain_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WORD_WIDTH*NUM_WORDS-1:0] buf_q;
    logic [WORD_WIDTH-1:0] word_sel;
    logic streaming, is_last, beat, accept;

    assign streaming = (state_q == STREAM);
    assign is_last   = streaming && (cnt_q == LAST_IDX);
    assign beat      = streaming && i_tready;
    // Accepting on the last handshake lets the next row follow with no bubble.
    assign i_ready   = (state_q == IDLE) || (beat && is_last);
    assign accept    = i_load && i_ready;

    gemm_drain_reg #(
        .WORD_WIDTH(WORD_WIDTH * NUM_WORDS)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .clk_en(accept),
        .d_i   (i_data),
        .q_o   (buf_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = STREAM;
            cnt_d   = '0;
        end else if (beat) begin
            if (is_last) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        word_sel = '0;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                word_sel = buf_q[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    assign o_tvalid = streaming;
    assign o_tlast  = is_last;
    assign o_tdata  = streaming ? word_sel : '0;

`ifdef GEMM_DRAIN_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (o_tvalid && !i_tready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign o_stall_cycles = stall_q;
`else
    assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_gemm_drain.sv
// Directed self-checking bench for gemm_drain (4-word/32-bit and 1-word/8-bit builds).
module tb_gemm_drain;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [127:0] data;
    logic         ready;
    logic         tvalid;
    logic [31:0]  tdata;
    logic         tlast;
    logic         tready;
    logic [31:0]  stall;

    logic         s_load;
    logic [7:0]   s_data;
    logic         s_ready;
    logic         s_tvalid;
    logic [7:0]   s_tdata;
    logic         s_tlast;
    logic         s_tready;
    logic [31:0]  s_stall;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef GEMM_DRAIN_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd3;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    always #5 clk = ~clk;

    gemm_drain #(
        .WORD_WIDTH(32),
        .NUM_WORDS (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_load        (load),
        .i_data        (data),
        .i_ready       (ready),
        .o_tvalid      (tvalid),
        .o_tdata       (tdata),
        .o_tlast       (tlast),
        .i_tready      (tready),
        .o_stall_cycles(stall)
    );

    gemm_drain #(
        .WORD_WIDTH(8),
        .NUM_WORDS (1)
    ) dut1 (
        .clk           (clk),
        .reset         (reset),
        .i_load        (s_load),
        .i_data        (s_data),
        .i_ready       (s_ready),
        .o_tvalid      (s_tvalid),
        .o_tdata       (s_tdata),
        .o_tlast       (s_tlast),
        .i_tready      (s_tready),
        .o_stall_cycles(s_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then leave a settle gap so inputs can be driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_chk(input string tag, input logic [31:0] d, input logic l, input logic r);
        #1;
        chk({tag, ".tvalid"}, {63'd0, tvalid}, 64'd1);
        chk({tag, ".tdata"},  {32'd0, tdata},  {32'd0, d});
        chk({tag, ".tlast"},  {63'd0, tlast},  {63'd0, l});
        chk({tag, ".ready"},  {63'd0, ready},  {63'd0, r});
    endtask

    localparam logic [127:0] ROW1 = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] ROW2 = {32'hD, 32'hC, 32'hB, 32'hA};
    localparam logic [127:0] ROW3 = {32'h04, 32'h03, 32'h02, 32'h01};
    localparam logic [127:0] JUNK = {4{32'hDEAD_BEEF}};

    initial begin
        reset = 1'b1; load = 1'b0; data = '0; tready = 1'b1;
        s_load = 1'b0; s_data = '0; s_tready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst.tvalid", {63'd0, tvalid}, 64'd0);
        chk("rst.tlast",  {63'd0, tlast},  64'd0);
        chk("rst.tdata",  {32'd0, tdata},  64'd0);
        chk("rst.ready",  {63'd0, ready},  64'd1);
        chk("rst.stall",  {32'd0, stall},  64'd0);

        // Basic row
        tick();
        load = 1'b1; data = ROW1;
        #1 chk("basic.ready_idle", {63'd0, ready}, 64'd1);
        tick();
        load = 1'b0;
        beat_chk("basic.w0", 32'h11, 1'b0, 1'b0);
        tick(); beat_chk("basic.w1", 32'h22, 1'b0, 1'b0);
        tick(); beat_chk("basic.w2", 32'h33, 1'b0, 1'b0);
        tick(); beat_chk("basic.w3", 32'h44, 1'b1, 1'b1);
        tick();
        #1;
        chk("basic.done_tvalid", {63'd0, tvalid}, 64'd0);
        chk("basic.done_ready",  {63'd0, ready},  64'd1);

        // Back-pressure for three cycles on word 0x22
        load = 1'b1; data = ROW1;
        tick();
        load = 1'b0;
        beat_chk("bp.w0", 32'h11, 1'b0, 1'b0);
        tick();
        tready = 1'b0;
        beat_chk("bp.s0", 32'h22, 1'b0, 1'b0);
        tick(); beat_chk("bp.s1", 32'h22, 1'b0, 1'b0);
        tick(); beat_chk("bp.s2", 32'h22, 1'b0, 1'b0);
        tick();
        tready = 1'b1;
        beat_chk("bp.release", 32'h22, 1'b0, 1'b0);
        chk("bp.stall", {32'd0, stall}, {32'd0, EXP_STALL});
        tick(); beat_chk("bp.w2", 32'h33, 1'b0, 1'b0);
        tick();
        // Back-to-back: next row offered on the tlast beat
        load = 1'b1; data = ROW2;
        beat_chk("b2b.w3", 32'h44, 1'b1, 1'b1);
        tick();
        load = 1'b0; data = JUNK;
        beat_chk("b2b.r2w0", 32'hA, 1'b0, 1'b0);
        tick(); beat_chk("b2b.r2w1", 32'hB, 1'b0, 1'b0);
        tick(); beat_chk("b2b.r2w2", 32'hC, 1'b0, 1'b0);
        tick(); beat_chk("b2b.r2w3", 32'hD, 1'b1, 1'b1);
        tick();
        #1 chk("b2b.idle", {63'd0, tvalid}, 64'd0);

        // Load while busy
        load = 1'b1; data = ROW1;
        tick();
        load = 1'b0;
        beat_chk("busy.w0", 32'h11, 1'b0, 1'b0);
        tick();
        load = 1'b1; data = JUNK;
        beat_chk("busy.pulse", 32'h22, 1'b0, 1'b0);
        tick();
        load = 1'b1; data = ROW3;
        beat_chk("busy.w2", 32'h33, 1'b0, 1'b0);
        tick(); beat_chk("busy.w3", 32'h44, 1'b1, 1'b1);
        tick();
        load = 1'b0; data = JUNK;
        beat_chk("busy.r3w0", 32'h01, 1'b0, 1'b0);
        tick(); beat_chk("busy.r3w1", 32'h02, 1'b0, 1'b0);

        // Reset mid-row after two words
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mrst.tvalid", {63'd0, tvalid}, 64'd0);
        chk("mrst.tlast",  {63'd0, tlast},  64'd0);
        chk("mrst.tdata",  {32'd0, tdata},  64'd0);
        chk("mrst.ready",  {63'd0, ready},  64'd1);
        chk("mrst.stall",  {32'd0, stall},  64'd0);
        load = 1'b1; data = ROW1;
        tick();
        load = 1'b0;
        beat_chk("mrst.restart", 32'h11, 1'b0, 1'b0);

        // Single-word rows, back-to-back
        s_load = 1'b1; s_data = 8'h5A;
        #1 chk("one.ready0", {63'd0, s_ready}, 64'd1);
        tick();
        s_data = 8'hA5;
        #1;
        chk("one.tvalid0", {63'd0, s_tvalid}, 64'd1);
        chk("one.tdata0",  {56'd0, s_tdata},  64'h5A);
        chk("one.tlast0",  {63'd0, s_tlast},  64'd1);
        chk("one.ready1",  {63'd0, s_ready},  64'd1);
        tick();
        s_load = 1'b0;
        #1;
        chk("one.tvalid1", {63'd0, s_tvalid}, 64'd1);
        chk("one.tdata1",  {56'd0, s_tdata},  64'hA5);
        chk("one.tlast1",  {63'd0, s_tlast},  64'd1);
        chk("one.ready2",  {63'd0, s_ready},  64'd1);
        tick();
        #1;
        chk("one.idle",    {63'd0, s_tvalid}, 64'd0);
        chk("one.ready3",  {63'd0, s_ready},  64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
